// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end that time-shares one combinational multiplier.
// Granted operands are held for LAT cycles, then the product is returned over valid/ready.
module mul_arbiter #(
    parameter int N    = 24,
    parameter int NREQ = 2,
    parameter int LAT  = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_m,
    input  logic [NREQ*N-1:0]   req_q,
    output logic [N-1:0]        mul_m,
    output logic [N-1:0]        mul_q,
    input  logic [2*N-1:0]      mul_r,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*N-1:0]      rsp_r,
    output logic                busy
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   mul_m_q, mul_m_d;
    logic [N-1:0]   mul_q_q, mul_q_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [2*N-1:0] rsp_r_q, rsp_r_d;

    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan_idx;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan_idx = IDW'((int'(ptr_q) + off) % NREQ);
            if (!grant_vld && req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mul_m_d     = mul_m_q;
        mul_q_d     = mul_q_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_r_d     = rsp_r_q;
        req_ready   = '0;

        unique case (state_q)
            StIdle: begin
                // rstn gating keeps req_ready low throughout reset.
                req_ready[grant_idx] = grant_vld & rstn;
                if (grant_vld) begin
                    mul_m_d  = req_m[grant_idx*N +: N];
                    mul_q_d  = req_q[grant_idx*N +: N];
                    rsp_id_d = grant_idx;
                    cnt_d    = CW'(LAT - 1);
                    if (grant_idx == IDW'(NREQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_idx + 1'b1;
                    end
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_r_d     = mul_r;
                    rsp_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cnt_q       <= '0;
            mul_m_q     <= '0;
            mul_q_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_r_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            mul_m_q     <= mul_m_d;
            mul_q_q     <= mul_q_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_r_q     <= rsp_r_d;
        end
    end

    assign mul_m     = mul_m_q;
    assign mul_q     = mul_q_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares one combinational `unsigned_mul` instance (mantissa multiplier) between `NREQ` requesters in the floating-point unit. It accepts one operand pair at a time with a valid/ready handshake and holds the operands stable on the multiplier for `LAT` cycles, so the multiplier is timed as a multicycle path. It then registers the 2N-bit product and returns it with the requester ID over a valid/ready response channel.

## Interface
- `N`, 24: operand width. Must match the shared multiplier's `N`.
- `NREQ`, 2: number of requesters, ≥2.
- `LAT`, 2: multicycle budget of the multiplier, in cycles, ≥1.
- `IDW`, `$clog2(NREQ)`: requester-ID width (derived, not overridden).
- `clk`  in  1  single clock; all state on rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_m`  in  NREQ*N  multiplicands; requester i uses bits [i*N +: N].
- `req_q`  in  NREQ*N  multipliers; same packing.
- `mul_m`  out  N  operand M to the shared multiplier.
- `mul_q`  out  N  operand Q to the shared multiplier.
- `mul_r`  in  2N  product from the shared multiplier.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_r`.
- `rsp_r`  out  2N  registered product.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- There are three states: IDLE, BUSY and DONE. A round-robin pointer `ptr` (IDW bits) tracks priority.
- **IDLE**
  - Grant `g` is the first index with `req_valid` set, searching from `ptr` upward and wrapping modulo NREQ.
  - `req_ready[g]` is driven high combinationally in the same cycle. All other `req_ready` bits are low.
  - If no `req_valid` bit is set, all `req_ready` bits are low.
- **Accept** (IDLE and `req_valid[g]`, at the clock edge):
  - `mul_m` ← `req_m[g]`, `mul_q` ← `req_q[g]`, `rsp_id` ← g.
  - `cnt` ← LAT−1, `ptr` ← (g+1) mod NREQ, state ← BUSY.
- **BUSY**
  - `req_ready` is all zero.
  - `mul_m` and `mul_q` are held constant.
  - If `cnt` ≠ 0: `cnt` decrements.
  - If `cnt` = 0: `rsp_r` ← `mul_r`, `rsp_valid` ← 1, state ← DONE.
- **DONE**
  - `rsp_valid`, `rsp_id` and `rsp_r` are held stable until `rsp_ready` is sampled high.
  - On that edge: `rsp_valid` ← 0, state ← IDLE.
  - `req_ready` stays zero throughout DONE, including the handshake cycle.
- Arithmetic is performed entirely in the external multiplier, which must compute R = M·Q as a 2N-bit unsigned product. This block does no arithmetic beyond `cnt` and `ptr`.
- `mul_m` and `mul_q` keep the last accepted operands after DONE. They change only on the next accept.

## Timing
- **Reset** (`rstn` low, asynchronous, any state including mid-BUSY or mid-DONE):
  - state = IDLE, `ptr` = 0, `cnt` = 0.
  - `mul_m` = `mul_q` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_r` = 0, `busy` = 0.
  - Any in-flight operation is discarded with no response.
  - `req_ready` is all zero while `rstn` is low.
- **Latency:** accept at edge k gives `rsp_valid` high from edge k+LAT. With LAT = 1, BUSY lasts exactly one cycle.
- **Throughput:**
  - With `rsp_ready` held high, the response handshake occurs at edge k+LAT+1 and the next accept at edge k+LAT+2.
  - Maximum rate is therefore one operation per LAT+2 cycles.
- **Handshake rules:**
  - A requester may drop `req_valid` before it is granted; the grant is re-evaluated every IDLE cycle.
  - `req_m` and `req_q` are sampled only on the accept edge.
- **Fairness:**
  - With all requesters continuously valid, grants rotate 0, 1, …, NREQ−1, 0.
  - `ptr` wraps from NREQ−1 to 0.
  - A lone valid requester is granted regardless of `ptr`.
- **Simultaneous events:** a new `req_valid` arriving during BUSY or DONE waits. It is neither lost nor accepted early.

## Test plan
- **Reset mid-operation:** N=8, LAT=2. Accept req0 with M=0xFF, Q=0xFF. Pulse `rstn` low while in BUSY, then release. Required: all outputs at reset values, no `rsp_valid`, next grant goes to req0 (`ptr` = 0).
- **Single operation:** N=8, LAT=2. req0 presents M=0xFF, Q=0xFF; accept at edge k. Required: `rsp_valid` rises at edge k+2 with `rsp_r`=0xFE01 and `rsp_id`=0; `busy` is high from edge k until the handshake.
- **Round-robin rotation:** NREQ=2, both requesters valid continuously, `rsp_ready`=1. Required: grants alternate 0, 1, 0, 1 with products matching each requester's operands, and consecutive accepts are 4 cycles apart.
- **Response backpressure:** hold `rsp_ready`=0 for 10 cycles after `rsp_valid` rises with req1 operands M=3, Q=5. Required: `rsp_r`=15 and `rsp_id`=1 held stable, all `req_ready` bits zero; state returns to IDLE one cycle after `rsp_ready` rises.
- **Boundary operands:** M=0, Q=0xFF gives `rsp_r`=0. M=1, Q=0x80 gives `rsp_r`=0x0080. Run with LAT=1 and LAT=4; `rsp_valid` must rise exactly LAT cycles after accept.
- **Withdrawn request:** req1 raises `req_valid` during BUSY, then drops it before the next IDLE cycle. Required: req1 is never granted and no spurious response is produced.
